uart_rx_core: RTL and testbench

//  Parametrised UART receiver for the uart module family: oversampled mid-bit sampling, configurable frame
//  (data bits, parity mode, stop bits), parity/framing/overrun error flags, valid/ready output handshake.

---
 rtl/uart_rx_core.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// ============================================================================
// uart_rx_core : oversampled UART receiver, configurable frame, valid/ready out
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 done;
  logic                 rx_meta, rx_s;

  // Two-flop synchroniser; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      stop_idx <= stop_idx_n;
      shift    <= shift_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    stop_idx_n = stop_idx;
    shift_n    = shift;
    perr_n     = perr;
    ferr_n     = ferr;
    done       = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = ST_START;
      end

      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            idx_n   = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (idx == IDX_LAST) begin
            idx_n      = '0;
            stop_idx_n = 1'b0;
            state_n    = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_PAR: begin
        if (cnt == FULL_LAST) begin
          cnt_n      = '0;
          perr_n     = (PARITY == 2) ? ~(^shift ^ rx_s) : (^shift ^ rx_s);
          stop_idx_n = 1'b0;
          state_n    = ST_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n  = '0;
          ferr_n = ferr | ~rx_s;
          if (stop_idx == STOP_LAST) begin
            // Leave half a bit early so the next start edge is never missed.
            done    = 1'b1;
            state_n = rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            stop_idx_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output holding register: a completed frame is dropped if the previous word is still unaccepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (!valid || ready) begin
        data       <= shift;
        parity_err <= perr;
        frame_err  <= ferr_n;
        valid      <= 1'b1;
        if (valid) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: four configurations driven one at a time,
// expected words computed from the frame contents that were put on the line.
`default_nettype none

module tb_uart_rx_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] rx_line = 4'hF;
  logic [3:0] rdy = 4'hF;
  wire  [3:0] vld, pe, fe, ov;
  wire  [7:0] d0, d1, d2;
  wire  [6:0] d3;
  wire  [3:0][8:0] dat;

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {1'b0, d2};
  assign dat[3] = {2'b00, d3};

  // inst 0: 8N1, inst 1: 8E1, inst 2: 8O1, inst 3: 7N2 at 5 clk/bit
  int cpb_a [4] = '{16, 16, 16, 5};
  int bits_a[4] = '{8, 8, 8, 7};
  int par_a [4] = '{0, 1, 2, 0};
  int stop_a[4] = '{1, 1, 1, 2};

  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .rx_i(rx_line[0]), .data(d0), .valid(vld[0]), .ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));
  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .rx_i(rx_line[1]), .data(d1), .valid(vld[1]), .ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));
  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .rx_i(rx_line[2]), .data(d2), .valid(vld[2]), .ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));
  uart_rx_core #(.CLKS_PER_BIT(5), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .rx_i(rx_line[3]), .data(d3), .valid(vld[3]), .ready(rdy[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]));

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    int         width;
  } word_t;

  word_t got_q[$];
  int    run[4] = '{0, 0, 0, 0};

  // Accepted-word collector; width = number of cycles valid was high for that word.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        run[i] <= 0;
      end else if (vld[i] && rdy[i]) begin
        got_q.push_back('{i, dat[i], pe[i], fe[i], run[i] + 1});
        run[i] <= 0;
      end else if (vld[i]) begin
        run[i] <= run[i] + 1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] e_d;
  logic       e_pe, e_fe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int inst, input logic b, input int cycles);
    rx_line[inst] = b;
    repeat (cycles) @(negedge clk);
  endtask

  // Puts one frame on the line and records the word the receiver should report for it.
  task automatic send(input int inst, input logic [8:0] d_in, input bit flip_par, input bit bad_stop);
    int nb;
    int cpb;
    int ones;
    logic [8:0] d;
    logic pbit;
    nb   = bits_a[inst];
    cpb  = cpb_a[inst];
    d    = d_in & ((9'd1 << nb) - 9'd1);
    ones = $countones(d);
    pbit = 1'b0;
    if (par_a[inst] == 1) pbit = ((ones % 2) == 1) ^ flip_par;
    if (par_a[inst] == 2) pbit = ((ones % 2) == 0) ^ flip_par;
    drive(inst, 1'b0, cpb);
    for (int k = 0; k < nb; k++) drive(inst, d[k], cpb);
    if (par_a[inst] != 0) drive(inst, pbit, cpb);
    for (int s = 0; s < stop_a[inst]; s++) drive(inst, !(bad_stop && s == 0), cpb);
    e_d  = d;
    e_pe = (par_a[inst] == 1) ? (((ones + pbit) % 2) == 1) :
           (par_a[inst] == 2) ? (((ones + pbit) % 2) == 0) : 1'b0;
    e_fe = bad_stop;
  endtask

  task automatic expect_word(input string tag, input int inst, input bit chk_w);
    word_t w;
    chk({tag, ".count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      chk({tag, ".inst"}, w.inst, inst);
      chk({tag, ".data"}, w.d, e_d);
      chk({tag, ".parity_err"}, w.pe, e_pe);
      chk({tag, ".frame_err"}, w.fe, e_fe);
      if (chk_w) chk({tag, ".valid_width"}, w.width, 1);
    end
    got_q.delete();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset.valid", vld[i], 0);
      chk("reset.data", dat[i], 0);
      chk("reset.parity_err", pe[i], 0);
      chk("reset.frame_err", fe[i], 0);
      chk("reset.overrun", ov[i], 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 8N1 word
    send(0, 9'hA5, 1'b0, 1'b0);
    drive(0, 1'b1, 32);
    expect_word("t1_8n1", 0, 1'b1);

    // Parity: even then odd, with good and bad parity bits on 0x07
    send(1, 9'h07, 1'b1, 1'b0);  drive(1, 1'b1, 32); expect_word("t2_even_bad", 1, 1'b1);
    send(1, 9'h07, 1'b0, 1'b0);  drive(1, 1'b1, 32); expect_word("t2_even_ok", 1, 1'b1);
    send(2, 9'h07, 1'b1, 1'b0);  drive(2, 1'b1, 32); expect_word("t2_odd_bad", 2, 1'b1);
    send(2, 9'h07, 1'b0, 1'b0);  drive(2, 1'b1, 32); expect_word("t2_odd_ok", 2, 1'b1);

    // Short glitch must not start a frame
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 48);
    chk("t3_glitch.valid", vld[0], 0);
    chk("t3_glitch.count", got_q.size(), 0);
    send(0, 9'h3C, 1'b0, 1'b0);
    drive(0, 1'b1, 32);
    expect_word("t3_after", 0, 1'b1);

    // Bad stop bit followed by a long break: one word only
    send(0, 9'h96, 1'b0, 1'b1);
    drive(0, 1'b0, 40 * 16);
    expect_word("t4_break", 0, 1'b1);
    drive(0, 1'b1, 32);
    chk("t4_quiet.count", got_q.size(), 0);
    send(0, 9'h11, 1'b0, 1'b0);
    drive(0, 1'b1, 32);
    expect_word("t4_recover", 0, 1'b1);

    // Overrun with ready low
    rdy[0] = 1'b0;
    send(0, 9'h01, 1'b0, 1'b0);
    drive(0, 1'b1, 32);
    chk("t5_first.valid", vld[0], 1);
    chk("t5_first.data", dat[0], 9'h01);
    chk("t5_first.overrun", ov[0], 0);
    send(0, 9'h02, 1'b0, 1'b0);
    drive(0, 1'b1, 32);
    chk("t5_second.valid", vld[0], 1);
    chk("t5_second.data", dat[0], 9'h01);
    chk("t5_second.overrun", ov[0], 1);
    chk("t5_second.count", got_q.size(), 0);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("t5_accept.valid", vld[0], 0);
    chk("t5_accept.overrun", ov[0], 0);
    e_d = 9'h01; e_pe = 1'b0; e_fe = 1'b0;
    expect_word("t5_word", 0, 1'b0);

    // Randomised frames across all configurations
    for (int r = 0; r < 16; r++) begin
      int  inst;
      bit  flip;
      bit  bad;
      inst = r % 4;
      flip = (par_a[inst] != 0) && ($urandom_range(0, 1) == 1);
      bad  = ($urandom_range(0, 3) == 0);
      send(inst, 9'($urandom), flip, bad);
      drive(inst, 1'b1, 2 * cpb_a[inst]);
      expect_word("rnd", inst, 1'b1);
    end

    // 7N2 back-to-back, reset during the second frame
    send(3, 9'h55, 1'b0, 1'b0);
    drive(3, 1'b0, 5);
    drive(3, 1'b0, 5);
    drive(3, 1'b1, 5);
    drive(3, 1'b0, 5);
    expect_word("t6_first", 3, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_reset.valid", vld[3], 0);
    chk("t6_reset.data", dat[3], 0);
    chk("t6_reset.parity_err", pe[3], 0);
    chk("t6_reset.frame_err", fe[3], 0);
    chk("t6_reset.overrun", ov[3], 0);
    drive(3, 1'b1, 5);
    drive(3, 1'b0, 5);
    drive(3, 1'b1, 5);
    drive(3, 1'b0, 5);
    drive(3, 1'b1, 10);
    reset = 1'b0;
    drive(3, 1'b1, 40);
    chk("t6_after.valid", vld[3], 0);
    chk("t6_after.count", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
